execute_unit: RTL and testbench
===============================

EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-002 SHALL have port: nreset  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  operands valid; sampled only in IDLE.
REQ-004 SHALL have port: op  input  4  ARM data-processing opcode (AND..MVN, 0000-1111).
REQ-005 SHALL have port: set_flags  input  1  S bit; CPSR update request.
REQ-006 SHALL have port: cond  input  4  ARM condition field (EQ=0 .. AL=14, 15=never).
REQ-007 SHALL have port: use_imm  input  1  operand2 = rotated immediate, else rm_data.
REQ-008 SHALL have port: imm8  input  8  immediate value.
REQ-009 SHALL have port: rotate  input  4  immediate rotate-right amount in units of 2 bits.
REQ-010 SHALL have port: rn_data  input  32  first operand (register file read port).
REQ-011 SHALL have port: rm_data  input  32  register operand2.
REQ-012 SHALL have port: result  output  32  registered result for Rd write-back.
REQ-013 SHALL have port: wr_en  output  1  Rd write enable; high only in DONE.
REQ-014 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port: cpsr  output  4  registered flags {N,Z,C,V}.

Function
REQ-017 SHALL implement FSM states IDLE, CHECK, ROT, EXEC, DONE.
REQ-018 IDLE + start SHALL latch op, set_flags, cond, operand2 source (imm8 zero-extended or rm_data), rn_data, rotate count; next CHECK.
REQ-019 start outside IDLE SHALL be ignored; latched operands SHALL NOT change until next IDLE.
REQ-020 CHECK SHALL evaluate cond against current cpsr per ARM rules; fail -> DONE with wr_en=0, cpsr and result unchanged.
REQ-021 CHECK pass: use_imm and rotate!=0 -> ROT; else -> EXEC.
REQ-022 ROT SHALL rotate operand2 right by 2 bits per cycle and decrement count; count reaching 0 -> EXEC.
REQ-023 Shifter carry SHALL be bit31 of the rotated operand when rotate!=0, else current C.
REQ-024 EXEC SHALL compute 32-bit result, flags on a 33-bit internal sum, then -> DONE.
REQ-025 Ops: AND, EOR, SUB(rn-op2), RSB(op2-rn), ADD, ADC(+C), SBC(rn-op2-!C), RSC(op2-rn-!C), TST, TEQ, CMP, CMN, ORR, MOV(op2), BIC(rn&~op2), MVN(~op2).
REQ-026 Arithmetic ops SHALL set C = carry-out (subtract: C = NOT borrow) and V = signed overflow; logical ops SHALL set C = shifter carry, V unchanged.
REQ-027 N = result[31], Z = (result==0) for all flag-updating ops.
REQ-028 cpsr SHALL update in EXEC when set_flags=1 or op is TST/TEQ/CMP/CMN; otherwise hold.
REQ-029 TST/TEQ/CMP/CMN SHALL produce wr_en=0 and leave result unchanged.
REQ-030 DONE SHALL assert done=1 for exactly one cycle, wr_en=1 for writing ops with passed cond; next IDLE.
REQ-031 Latency: done high in cycle after edge 2+n (n = rotation cycles) counted from start-sampling edge 0; cond fail: after edge 1.
REQ-032 Wrap-around: 0xFFFFFFFF+1 SHALL give result 0, Z=1, C=1, V=0.

Reset
REQ-033 nreset=0 at a clock edge SHALL force IDLE, result=0, wr_en=0, done=0, busy=0, cpsr=0000, from any state including mid-ROT.
REQ-034 start asserted during reset SHALL be ignored; first acceptance is at the first edge with nreset=1.

Structure
REQ-035 Opcode enum, condition enum, FSM state enum and CPSR bit indices SHALL live in shared package cpu_pkg.
REQ-036 Condition evaluation SHALL be one combinational sub-module cond_check (cond, cpsr -> pass).

Verification
REQ-037 ADD S, rn=0x7FFFFFFF, rm=1, cond=AL -> result 0x80000000, cpsr N=1 Z=0 C=0 V=1, done 3 cycles after start.
REQ-038 MOV imm8=0xFF rotate=4 -> result 0xFF000000 after 4 ROT cycles (done 7 cycles after start), C=1 if S.
REQ-039 CMP rn=5 op2=5 then ADDNE -> cpsr Z=1 C=1; ADDNE completes in 2 cycles, wr_en=0, result unchanged.
REQ-040 SUB S rn=0 op2=1 -> result 0xFFFFFFFF, N=1 C=0; following SBC rn=10 op2=3 -> 6.
REQ-041 nreset low during ROT (rotate=8) -> next cycle IDLE, busy=0, cpsr=0; new start accepted normally.
REQ-042 start held high for 10 cycles -> exactly one operation per IDLE visit, operands unchanged while busy.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the execute stage: opcodes, condition codes, FSM states
// and CPSR flag positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ROT   = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // cpsr is packed {N,Z,C,V}
  localparam int CPSR_N = 3;
  localparam int CPSR_Z = 2;
  localparam int CPSR_C = 1;
  localparam int CPSR_V = 0;

  // Compare/test ops only update flags and never write Rd.
  function automatic logic writes_rd(input op_t op);
    return !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluation against the current {N,Z,C,V} flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cpsr,
  output logic       pass
);

  logic n, z, c, v;

  assign n = cpsr[CPSR_N];
  assign z = cpsr[CPSR_Z];
  assign c = cpsr[CPSR_C];
  assign v = cpsr[CPSR_V];

  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// Multi-cycle ARM data-processing execute stage: condition check, iterative
// immediate rotation (2 bits per cycle), ALU with flag generation, Rd write-back.
module execute_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        set_flags,
  input  logic [3:0]  cond,
  input  logic        use_imm,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rotate,
  input  logic [31:0] rn_data,
  input  logic [31:0] rm_data,
  output logic [31:0] result,
  output logic        wr_en,
  output logic        done,
  output logic        busy,
  output logic [3:0]  cpsr
);

  // Handshake: start is a valid strobe taken only while busy=0 (IDLE); the
  // operands are captured on that edge and held until the next IDLE. done
  // pulses for exactly one cycle, with wr_en qualifying the result for Rd.

  state_t      state, state_d;
  op_t         op_q;
  cond_t       cond_q;
  logic        s_q;
  logic        rot_nz_q;
  logic [3:0]  cnt_q;
  logic [31:0] rn_q, op2_q;
  logic [31:0] result_q;
  logic [3:0]  cpsr_q;
  logic        wr_ok_q;
  logic        cond_pass;

  cond_check u_cond_check (
    .cond (cond_q),
    .cpsr (cpsr_q),
    .pass (cond_pass)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = CHECK;
      CHECK: begin
        if (!cond_pass)        state_d = DONE;
        else if (cnt_q != 4'd0) state_d = ROT;
        else                   state_d = EXEC;
      end
      ROT:     if (cnt_q == 4'd1) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU: every arithmetic op is x + y + cin on a 33-bit sum.
  logic [31:0] x, y, logic_res, alu_res;
  logic        cin, is_arith, shc;
  logic [32:0] sum;
  logic [3:0]  flags;
  logic        writes, upd;

  assign shc = rot_nz_q ? op2_q[31] : cpsr_q[CPSR_C];

  always_comb begin
    x         = rn_q;
    y         = op2_q;
    cin       = 1'b0;
    logic_res = 32'd0;
    is_arith  = 1'b0;
    case (op_q)
      OP_AND, OP_TST: logic_res = rn_q & op2_q;
      OP_EOR, OP_TEQ: logic_res = rn_q ^ op2_q;
      OP_ORR:         logic_res = rn_q | op2_q;
      OP_MOV:         logic_res = op2_q;
      OP_BIC:         logic_res = rn_q & ~op2_q;
      OP_MVN:         logic_res = ~op2_q;
      OP_SUB, OP_CMP: begin is_arith = 1'b1; y = ~op2_q; cin = 1'b1; end
      OP_RSB:         begin is_arith = 1'b1; x = op2_q; y = ~rn_q; cin = 1'b1; end
      OP_ADD, OP_CMN: begin is_arith = 1'b1; end
      OP_ADC:         begin is_arith = 1'b1; cin = cpsr_q[CPSR_C]; end
      OP_SBC:         begin is_arith = 1'b1; y = ~op2_q; cin = cpsr_q[CPSR_C]; end
      OP_RSC:         begin is_arith = 1'b1; x = op2_q; y = ~rn_q; cin = cpsr_q[CPSR_C]; end
    endcase
    sum     = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    alu_res = is_arith ? sum[31:0] : logic_res;
    flags[CPSR_N] = alu_res[31];
    flags[CPSR_Z] = (alu_res == 32'd0);
    flags[CPSR_C] = is_arith ? sum[32] : shc;
    flags[CPSR_V] = is_arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : cpsr_q[CPSR_V];
    writes  = writes_rd(op_q);
    upd     = s_q || !writes;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= IDLE;
      op_q     <= OP_AND;
      cond_q   <= COND_AL;
      s_q      <= 1'b0;
      rot_nz_q <= 1'b0;
      cnt_q    <= 4'd0;
      rn_q     <= 32'd0;
      op2_q    <= 32'd0;
      result_q <= 32'd0;
      cpsr_q   <= 4'd0;
      wr_ok_q  <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (start) begin
          op_q     <= op_t'(op);
          cond_q   <= cond_t'(cond);
          s_q      <= set_flags;
          rn_q     <= rn_data;
          op2_q    <= use_imm ? {24'd0, imm8} : rm_data;
          cnt_q    <= use_imm ? rotate : 4'd0;
          rot_nz_q <= use_imm && (rotate != 4'd0);
          wr_ok_q  <= 1'b0;
        end
        ROT: begin
          op2_q <= {op2_q[1:0], op2_q[31:2]};
          cnt_q <= cnt_q - 4'd1;
        end
        EXEC: begin
          if (writes) result_q <= alu_res;
          if (upd)    cpsr_q   <= flags;
          wr_ok_q <= writes;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign cpsr   = cpsr_q;
  assign done   = (state == DONE);
  assign wr_en  = (state == DONE) && wr_ok_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_execute_unit.sv
// Directed-vector bench for execute_unit with hand-computed results, flags
// and latencies.
module tb_execute_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        nreset, start, set_flags, use_imm;
  logic [3:0]  op, cond, rotate;
  logic [7:0]  imm8;
  logic [31:0] rn_data, rm_data, result;
  logic        wr_en, done, busy;
  logic [3:0]  cpsr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  execute_unit dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .op        (op),
    .set_flags (set_flags),
    .cond      (cond),
    .use_imm   (use_imm),
    .imm8      (imm8),
    .rotate    (rotate),
    .rn_data   (rn_data),
    .rm_data   (rm_data),
    .result    (result),
    .wr_en     (wr_en),
    .done      (done),
    .busy      (busy),
    .cpsr      (cpsr)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---- drivers ----
  task automatic set_ops(input logic [3:0] o, input logic s, input logic [3:0] c,
                         input logic ui, input logic [7:0] im, input logic [3:0] rot,
                         input logic [31:0] rn, input logic [31:0] rm);
    op = o; set_flags = s; cond = c; use_imm = ui; imm8 = im; rotate = rot;
    rn_data = rn; rm_data = rm;
  endtask

  // Presents one operation at a negedge; returns just after the accepting edge.
  task automatic drive(input logic [3:0] o, input logic s, input logic [3:0] c,
                       input logic ui, input logic [7:0] im, input logic [3:0] rot,
                       input logic [31:0] rn, input logic [31:0] rm);
    @(negedge clk);
    set_ops(o, s, c, ui, im, rot, rn, rm);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] o, input logic s, input logic [3:0] c,
                        input logic ui, input logic [7:0] im, input logic [3:0] rot,
                        input logic [31:0] rn, input logic [31:0] rm,
                        input logic [31:0] exp_res, input logic [3:0] exp_cpsr,
                        input int exp_lat, input logic exp_wr);
    int cyc;
    logic [31:0] exp;
    drive(o, s, c, ui, im, rot, rn, rm);
    exp_q.push_back(exp_res);
    wait_done(cyc);
    exp = exp_q.pop_front();
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_res"}, result, exp);
    check({tag, "_cpsr"}, {28'd0, cpsr}, {28'd0, exp_cpsr});
    check({tag, "_wr"}, {31'd0, wr_en}, {31'd0, exp_wr});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // ---- stimulus ----
  initial begin
    int cyc, n_done, n_idle;
    logic [31:0] res1, res2;

    // Reset with start held high: must be ignored until nreset rises.
    nreset = 1'b0;
    start  = 1'b1;
    set_ops(OP_MOV, 1'b0, COND_AL, 1'b0, 8'h00, 4'd0, 32'h0, 32'h12345678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_done",   {31'd0, done},  32'd0);
    check("rst_wr",     {31'd0, wr_en}, 32'd0);
    check("rst_result", result,         32'd0);
    check("rst_cpsr",   {28'd0, cpsr},  32'd0);
    nreset = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    check("first_accept_lat", cyc, 3);
    check("first_accept_res", result, 32'h12345678);
    @(negedge clk);

    //     tag      op      S     cond     imm   im8    rot  rn            rm            exp_res       cpsr  lat wr
    run_op("adds_v", OP_ADD, 1'b1, COND_AL, 1'b0, 8'h00, 4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 3, 1'b1);
    run_op("mov_rot", OP_MOV, 1'b1, COND_AL, 1'b1, 8'hFF, 4'd4, 32'h0,        32'h0,        32'hFF000000, 4'b1011, 7, 1'b1);
    run_op("cmp_eq", OP_CMP, 1'b0, COND_AL, 1'b0, 8'h00, 4'd0, 32'h5,        32'h5,        32'hFF000000, 4'b0110, 3, 1'b0);
    run_op("addne",  OP_ADD, 1'b1, COND_NE, 1'b0, 8'h00, 4'd0, 32'h1,        32'h1,        32'hFF000000, 4'b0110, 2, 1'b0);
    run_op("subs",   OP_SUB, 1'b1, COND_AL, 1'b0, 8'h00, 4'd0, 32'h0,        32'h1,        32'hFFFFFFFF, 4'b1000, 3, 1'b1);
    run_op("sbc",    OP_SBC, 1'b0, COND_AL, 1'b0, 8'h00, 4'd0, 32'd10,       32'd3,        32'h00000006, 4'b1000, 3, 1'b1);
    run_op("wrap",   OP_ADD, 1'b1, COND_AL, 1'b0, 8'h00, 4'd0, 32'hFFFFFFFF, 32'h1,        32'h00000000, 4'b0110, 3, 1'b1);
    run_op("bics",   OP_BIC, 1'b1, COND_AL, 1'b0, 8'h00, 4'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000, 4'b1010, 3, 1'b1);
    run_op("rsbs",   OP_RSB, 1'b1, COND_AL, 1'b0, 8'h00, 4'd0, 32'd3,        32'd10,       32'h00000007, 4'b0010, 3, 1'b1);
    run_op("mvncs",  OP_MVN, 1'b0, COND_CS, 1'b0, 8'h00, 4'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b0010, 3, 1'b1);
    run_op("teq",    OP_TEQ, 1'b0, COND_AL, 1'b0, 8'h00, 4'd0, 32'hAAAA,     32'hAAAA,     32'hFFFFFFFF, 4'b0110, 3, 1'b0);
    run_op("movnv",  OP_MOV, 1'b1, COND_NV, 1'b0, 8'h00, 4'd0, 32'h0,        32'h1234,     32'hFFFFFFFF, 4'b0110, 2, 1'b0);
    run_op("adcs",   OP_ADC, 1'b1, COND_AL, 1'b0, 8'h00, 4'd0, 32'd1,        32'd2,        32'h00000004, 4'b0000, 3, 1'b1);

    // Reset in the middle of an 8-step rotation.
    drive(OP_MOV, 1'b1, COND_AL, 1'b1, 8'h3C, 4'd8, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("midrot_busy", {31'd0, busy}, 32'd1);
    nreset = 1'b0;
    @(negedge clk);
    check("midrot_rst_busy",   {31'd0, busy}, 32'd0);
    check("midrot_rst_cpsr",   {28'd0, cpsr}, 32'd0);
    check("midrot_rst_result", result,        32'd0);
    check("midrot_rst_done",   {31'd0, done}, 32'd0);
    nreset = 1'b1;
    run_op("post_rst_add", OP_ADD, 1'b0, COND_AL, 1'b0, 8'h00, 4'd0, 32'd2, 32'd3, 32'h00000005, 4'b0000, 3, 1'b1);

    // start held high: one operation per IDLE visit, operands frozen while busy.
    @(negedge clk);
    set_ops(OP_MOV, 1'b0, COND_AL, 1'b0, 8'h00, 4'd0, 32'h0, 32'h11);
    start = 1'b1;
    @(posedge clk);
    #1 rm_data = 32'h22;
    n_done = 0; n_idle = 0; res1 = '0; res2 = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy) n_idle++;
      if (done) begin
        n_done++;
        if (n_done == 1) res1 = result;
        else res2 = result;
      end
    end
    start = 1'b0;
    check("hold_done_count", n_done, 2);
    check("hold_idle_count", n_idle, 2);
    check("hold_res1", res1, 32'h11);
    check("hold_res2", res2, 32'h22);
    wait_done(cyc);
    check("hold_tail_lat", cyc, 1);
    check("hold_tail_res", result, 32'h22);
    @(negedge clk);
    check("hold_end_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
